// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit types, port/deroute codes, routing reset defaults
// and the router FSM state type.
package noc_pkg;

    localparam logic [2:0] HEADER  = 3'b001;
    localparam logic [2:0] PAYLOAD = 3'b010;
    localparam logic [2:0] TAIL    = 3'b100;

    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_E = 3'd1,
        PORT_W = 3'd2,
        PORT_S = 3'd3,
        PORT_L = 3'd4
    } port_idx_e;

    // Deroute codes share the N/E/W/S numbering of the port index.
    typedef enum logic [1:0] {
        DR_N = 2'b00,
        DR_E = 2'b01,
        DR_W = 2'b10,
        DR_S = 2'b11
    } dr_code_e;

    localparam logic [7:0] RXY_RST = 8'h3C;
    localparam logic [3:0] CX_RST  = 4'hF;
    localparam logic [7:0] DR_RST  = 8'h00;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } route_state_e;

    function automatic logic [3:0] dir_onehot(input logic [1:0] code);
        dir_onehot = 4'b0001 << code;
    endfunction

endpackage

// File: rtl/lbdr_route_comb.sv
// Combinational LBDR core: minimal candidates, port priority/fork and the
// deroute fallback when no minimal port is usable.
module lbdr_route_comb
    import noc_pkg::*;
#(
    parameter int X_W     = 2,
    parameter int Y_W     = 2,
    parameter int FORK_EN = 0
) (
    input  logic [X_W+Y_W-1:0] cur_addr,
    input  logic [X_W+Y_W-1:0] dst_addr,
    input  logic [7:0]         rxy,
    input  logic [3:0]         cx,
    input  logic [7:0]         dr,
    output logic [4:0]         port_req,
    output logic               derouted,
    output logic               legal
);

    logic [X_W-1:0] x_cur;
    logic [X_W-1:0] x_dst;
    logic [Y_W-1:0] y_cur;
    logic [Y_W-1:0] y_dst;
    logic           n1;
    logic           s1;
    logic           e1;
    logic           w1;
    logic           l_hit;
    logic           cand_n;
    logic           cand_e;
    logic           cand_w;
    logic           cand_s;
    logic [3:0]     cand;
    logic [3:0]     sel;
    logic [1:0]     prim_code;
    logic [1:0]     dr_code;
    logic [3:0]     dr_port;
    logic           dr_ok;

    assign x_cur = cur_addr[X_W-1:0];
    assign y_cur = cur_addr[X_W+Y_W-1:X_W];
    assign x_dst = dst_addr[X_W-1:0];
    assign y_dst = dst_addr[X_W+Y_W-1:X_W];

    assign n1 = y_dst < y_cur;
    assign s1 = y_cur < y_dst;
    assign e1 = x_cur < x_dst;
    assign w1 = x_dst < x_cur;

    assign l_hit = ~n1 & ~s1 & ~e1 & ~w1;

    // rxy = {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}, cx = {Cs,Cw,Ce,Cn}
    assign cand_n = ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy[0]) | (n1 & w1 & rxy[1])) & cx[0];
    assign cand_e = ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy[2]) | (e1 & s1 & rxy[3])) & cx[1];
    assign cand_w = ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy[4]) | (w1 & s1 & rxy[5])) & cx[2];
    assign cand_s = ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy[6]) | (s1 & w1 & rxy[7])) & cx[3];
    assign cand   = {cand_s, cand_w, cand_e, cand_n};

    always_comb begin
        sel = 4'b0000;
        if (FORK_EN != 0) begin
            sel = cand;
        end else if (cand[0]) begin
            sel = 4'b0001;
        end else if (cand[1]) begin
            sel = 4'b0010;
        end else if (cand[2]) begin
            sel = 4'b0100;
        end else if (cand[3]) begin
            sel = 4'b1000;
        end
    end

    // The primary direction picks which 2-bit deroute code applies.
    always_comb begin
        prim_code = DR_W;
        if (n1) begin
            prim_code = DR_N;
        end else if (s1) begin
            prim_code = DR_S;
        end else if (e1) begin
            prim_code = DR_E;
        end
        case (prim_code)
            DR_N:    dr_code = dr[1:0];
            DR_E:    dr_code = dr[3:2];
            DR_W:    dr_code = dr[5:4];
            default: dr_code = dr[7:6];
        endcase
    end

    assign dr_port = dir_onehot(dr_code);
    assign dr_ok   = (|(dr_port & cx)) && (dr_code != prim_code);

    always_comb begin
        port_req = 5'b00000;
        derouted = 1'b0;
        legal    = 1'b0;
        if (l_hit) begin
            port_req = 5'b10000;
            legal    = 1'b1;
        end else if (|sel) begin
            port_req = {1'b0, sel};
            legal    = 1'b1;
        end else if (dr_ok) begin
            port_req = {1'b0, dr_port};
            derouted = 1'b1;
            legal    = 1'b1;
        end
    end

endmodule

// File: rtl/lbdr_dr_router.sv
// LBDR input-port router with deroute fallback: holds the loadable routing
// configuration and the per-packet FSM that latches the port request.
module lbdr_dr_router
    import noc_pkg::*;
#(
    parameter int          X_W          = 2,
    parameter int          Y_W          = 2,
    parameter int          FORK_EN      = 0,
    parameter int unsigned CUR_ADDR_RST = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [7:0]         cfg_rxy,
    input  logic [3:0]         cfg_cx,
    input  logic [7:0]         cfg_dr,
    input  logic [X_W+Y_W-1:0] cfg_addr,
    input  logic               flit_valid,
    input  logic [2:0]         flit_id,
    input  logic [X_W+Y_W-1:0] dst_addr,
    input  logic               out_ready,
    output logic [4:0]         port_req,
    output logic               req_valid,
    output logic               derouted,
    output logic               route_err,
    output logic               proto_err
);

    localparam int              A_W           = X_W + Y_W;
    localparam logic [A_W-1:0] CUR_ADDR_INIT = A_W'(CUR_ADDR_RST);

    logic [7:0]     rxy_q;
    logic [3:0]     cx_q;
    logic [7:0]     dr_q;
    logic [A_W-1:0] addr_q;

    route_state_e   state_q;
    route_state_e   state_next;
    logic [4:0]     port_req_next;
    logic           req_valid_next;
    logic           derouted_next;
    logic           route_err_next;
    logic           proto_err_next;

    logic [4:0]     route_port;
    logic           route_derouted;
    logic           route_legal;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxy_q  <= RXY_RST;
            cx_q   <= CX_RST;
            dr_q   <= DR_RST;
            addr_q <= CUR_ADDR_INIT;
        end else if (cfg_we) begin
            rxy_q  <= cfg_rxy;
            cx_q   <= cfg_cx;
            dr_q   <= cfg_dr;
            addr_q <= cfg_addr;
        end
    end

    lbdr_route_comb #(
        .X_W     (X_W),
        .Y_W     (Y_W),
        .FORK_EN (FORK_EN)
    ) u_route (
        .cur_addr (addr_q),
        .dst_addr (dst_addr),
        .rxy      (rxy_q),
        .cx       (cx_q),
        .dr       (dr_q),
        .port_req (route_port),
        .derouted (route_derouted),
        .legal    (route_legal)
    );

    // An unroutable header is left in the buffer; the FSM stays IDLE.
    always_comb begin
        state_next     = state_q;
        port_req_next  = port_req;
        req_valid_next = req_valid;
        derouted_next  = derouted;
        route_err_next = 1'b0;
        proto_err_next = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flit_valid && flit_id == HEADER) begin
                    if (route_legal) begin
                        state_next     = ST_HOLD;
                        port_req_next  = route_port;
                        req_valid_next = 1'b1;
                        derouted_next  = route_derouted;
                    end else begin
                        route_err_next = 1'b1;
                    end
                end else if (flit_valid && (flit_id == PAYLOAD || flit_id == TAIL)) begin
                    proto_err_next = 1'b1;
                end
            end
            ST_HOLD: begin
                if (flit_valid && flit_id == HEADER) begin
                    proto_err_next = 1'b1;
                end else if (flit_valid && flit_id == TAIL && out_ready) begin
                    state_next     = ST_IDLE;
                    port_req_next  = 5'b00000;
                    req_valid_next = 1'b0;
                    derouted_next  = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            port_req  <= 5'b00000;
            req_valid <= 1'b0;
            derouted  <= 1'b0;
            route_err <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state_q   <= state_next;
            port_req  <= port_req_next;
            req_valid <= req_valid_next;
            derouted  <= derouted_next;
            route_err <= route_err_next;
            proto_err <= proto_err_next;
        end
    end

endmodule

// File: tb/tb_lbdr_dr_router.sv
// Bench for lbdr_dr_router: single-port and fork instances driven together and
// compared each cycle against a coordinate-level routing and packet model.
module tb_lbdr_dr_router;
    import noc_pkg::*;

    localparam int X_W = 2;
    localparam int Y_W = 2;
    localparam int A_W = X_W + Y_W;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_we;
    logic [7:0]     cfg_rxy;
    logic [3:0]     cfg_cx;
    logic [7:0]     cfg_dr;
    logic [A_W-1:0] cfg_addr;
    logic           flit_valid;
    logic [2:0]     flit_id;
    logic [A_W-1:0] dst_addr;
    logic           out_ready;

    logic [4:0] port_req, port_req_f;
    logic       req_valid, req_valid_f;
    logic       derouted, derouted_f;
    logic       route_err, route_err_f;
    logic       proto_err, proto_err_f;

    logic [7:0] m_rxy;
    logic [3:0] m_cx;
    logic [7:0] m_dr;
    int         m_addr;
    bit         m_in_pkt;
    logic [4:0] m_req, m_req_f;
    bit         m_val, m_der, m_der_f, m_rerr, m_perr;

    int test_count = 0;
    int fail_count = 0;

    always #5 clk = ~clk;

    lbdr_dr_router #(.X_W(X_W), .Y_W(Y_W), .FORK_EN(0), .CUR_ADDR_RST(5)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_rxy(cfg_rxy), .cfg_cx(cfg_cx),
        .cfg_dr(cfg_dr), .cfg_addr(cfg_addr), .flit_valid(flit_valid), .flit_id(flit_id),
        .dst_addr(dst_addr), .out_ready(out_ready), .port_req(port_req),
        .req_valid(req_valid), .derouted(derouted), .route_err(route_err),
        .proto_err(proto_err)
    );

    lbdr_dr_router #(.X_W(X_W), .Y_W(Y_W), .FORK_EN(1), .CUR_ADDR_RST(5)) dut_fork (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_rxy(cfg_rxy), .cfg_cx(cfg_cx),
        .cfg_dr(cfg_dr), .cfg_addr(cfg_addr), .flit_valid(flit_valid), .flit_id(flit_id),
        .dst_addr(dst_addr), .out_ready(out_ready), .port_req(port_req_f),
        .req_valid(req_valid_f), .derouted(derouted_f), .route_err(route_err_f),
        .proto_err(proto_err_f)
    );

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        test_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Routing-word bit for "leave via first while second is also a productive way".
    function automatic int turn_bit(input int first, input int second);
        if (first == 0) return (second == 1) ? 0 : 1;
        if (first == 1) return (second == 0) ? 2 : 3;
        if (first == 2) return (second == 0) ? 4 : 5;
        return (second == 1) ? 6 : 7;
    endfunction

    // Ports numbered N=0, E=1, W=2, S=3, matching the connectivity bits.
    function automatic void model_route(input bit fork_mode, input int cur, input int dst,
                                        input logic [7:0] rxy, input logic [3:0] cx,
                                        input logic [7:0] dr, output logic [4:0] req,
                                        output bit der, output bit legal);
        int xc, yc, xd, yd, other, prim, code;
        bit want[4];
        bit cand[4];
        xc = cur % (1 << X_W);
        yc = cur >> X_W;
        xd = dst % (1 << X_W);
        yd = dst >> X_W;
        want[0] = (yd < yc);
        want[1] = (xd > xc);
        want[2] = (xd < xc);
        want[3] = (yd > yc);
        req = 5'b00000;
        der = 1'b0;
        legal = 1'b0;
        if (!(want[0] || want[1] || want[2] || want[3])) begin
            req = 5'b10000;
            legal = 1'b1;
            return;
        end
        for (int p = 0; p < 4; p++) begin
            if (p == 0 || p == 3) other = want[1] ? 1 : (want[2] ? 2 : -1);
            else                  other = want[0] ? 0 : (want[3] ? 3 : -1);
            cand[p] = want[p] && cx[p] && (other < 0 || rxy[turn_bit(p, other)]);
        end
        for (int p = 0; p < 4; p++) begin
            if (cand[p]) begin
                req[p] = 1'b1;
                legal = 1'b1;
                if (!fork_mode) break;
            end
        end
        if (legal) return;
        prim = want[0] ? 0 : (want[3] ? 3 : (want[1] ? 1 : 2));
        code = int'((dr >> (2 * prim)) & 8'd3);
        if (cx[code] && code != prim) begin
            req[code] = 1'b1;
            der = 1'b1;
            legal = 1'b1;
        end
    endfunction

    task automatic cycle();
        logic [4:0] r0, r1;
        bit d0, d1, l0, l1;
        if (rst) begin
            m_rxy = 8'h3C; m_cx = 4'hF; m_dr = 8'h00; m_addr = 5;
            m_in_pkt = 0; m_req = 0; m_req_f = 0; m_val = 0;
            m_der = 0; m_der_f = 0; m_rerr = 0; m_perr = 0;
        end else begin
            model_route(1'b0, m_addr, int'(dst_addr), m_rxy, m_cx, m_dr, r0, d0, l0);
            model_route(1'b1, m_addr, int'(dst_addr), m_rxy, m_cx, m_dr, r1, d1, l1);
            m_rerr = 0;
            m_perr = 0;
            if (!m_in_pkt) begin
                if (flit_valid && flit_id == HEADER) begin
                    if (l0) begin
                        m_in_pkt = 1; m_val = 1;
                        m_req = r0; m_req_f = r1; m_der = d0; m_der_f = d1;
                    end else begin
                        m_rerr = 1;
                    end
                end else if (flit_valid && (flit_id == PAYLOAD || flit_id == TAIL)) begin
                    m_perr = 1;
                end
            end else begin
                if (flit_valid && flit_id == HEADER) begin
                    m_perr = 1;
                end else if (flit_valid && flit_id == TAIL && out_ready) begin
                    m_in_pkt = 0; m_val = 0;
                    m_req = 0; m_req_f = 0; m_der = 0; m_der_f = 0;
                end
            end
            if (cfg_we) begin
                m_rxy = cfg_rxy; m_cx = cfg_cx; m_dr = cfg_dr; m_addr = int'(cfg_addr);
            end
        end
        @(posedge clk);
        #1;
        checkOutput("port_req",    8'(port_req),    8'(m_req));
        checkOutput("req_valid",   8'(req_valid),   8'(m_val));
        checkOutput("derouted",    8'(derouted),    8'(m_der));
        checkOutput("route_err",   8'(route_err),   8'(m_rerr));
        checkOutput("proto_err",   8'(proto_err),   8'(m_perr));
        checkOutput("fork_req",    8'(port_req_f),  8'(m_req_f));
        checkOutput("fork_valid",  8'(req_valid_f), 8'(m_val));
        checkOutput("fork_der",    8'(derouted_f),  8'(m_der_f));
        checkOutput("fork_rerr",   8'(route_err_f), 8'(m_rerr));
        checkOutput("fork_perr",   8'(proto_err_f), 8'(m_perr));
        rst = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic applyStimulus(input bit fv, input logic [2:0] id, input int dst, input bit ordy);
        flit_valid = fv;
        flit_id = id;
        dst_addr = A_W'(dst);
        out_ready = ordy;
        cycle();
    endtask

    task automatic setConfig(input logic [7:0] rxy, input logic [3:0] cx, input logic [7:0] dr, input int addr);
        cfg_rxy = rxy;
        cfg_cx = cx;
        cfg_dr = dr;
        cfg_addr = A_W'(addr);
        cfg_we = 1'b1;
        applyStimulus(1'b0, 3'b000, 0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_rxy = 8'h3C; cfg_cx = 4'hF; cfg_dr = 8'h00;
        cfg_addr = 4'd5; flit_valid = 1'b0; flit_id = 3'b000; dst_addr = '0; out_ready = 1'b0;
        applyStimulus(1'b0, 3'b000, 0, 1'b0);
        checkOutput("rst_req", 8'(port_req), 8'h00);
        checkOutput("rst_valid", 8'(req_valid), 8'h00);

        applyStimulus(1'b1, HEADER, 5, 1'b0);
        checkOutput("plan_local", 8'(port_req), 8'h10);
        applyStimulus(1'b1, TAIL, 0, 1'b1);
        applyStimulus(1'b1, HEADER, 0, 1'b0);
        checkOutput("plan_west", 8'(port_req), 8'h04);
        checkOutput("plan_west_der", 8'(derouted), 8'h00);
        applyStimulus(1'b1, TAIL, 0, 1'b1);
        applyStimulus(1'b1, HEADER, 15, 1'b0);
        checkOutput("plan_east", 8'(port_req), 8'h02);
        applyStimulus(1'b1, TAIL, 0, 1'b1);

        setConfig(8'h3C, 4'b1110, 8'h01, 5);
        applyStimulus(1'b1, HEADER, 1, 1'b0);
        checkOutput("deroute_req", 8'(port_req), 8'h02);
        checkOutput("deroute_flag", 8'(derouted), 8'h01);
        applyStimulus(1'b1, TAIL, 0, 1'b1);
        setConfig(8'h3C, 4'b0000, 8'h01, 5);
        applyStimulus(1'b1, HEADER, 1, 1'b0);
        checkOutput("noroute_err", 8'(route_err), 8'h01);
        checkOutput("noroute_req", 8'(port_req), 8'h00);
        applyStimulus(1'b1, PAYLOAD, 0, 1'b1);
        checkOutput("noroute_idle", 8'(proto_err), 8'h01);

        setConfig(8'hFF, 4'hF, 8'h00, 5);
        applyStimulus(1'b1, HEADER, 15, 1'b0);
        checkOutput("fork_es", 8'(port_req_f), 8'h0A);
        applyStimulus(1'b1, TAIL, 0, 1'b1);

        setConfig(8'h3C, 4'hF, 8'h00, 5);
        cfg_cx = 4'b0000; cfg_we = 1'b1;
        applyStimulus(1'b1, HEADER, 0, 1'b0);
        checkOutput("cfg_same_edge", 8'(port_req), 8'h04);
        applyStimulus(1'b1, TAIL, 0, 1'b1);
        setConfig(8'h3C, 4'hF, 8'h00, 5);

        applyStimulus(1'b1, HEADER, 13, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, PAYLOAD, 0, 1'b1);
        applyStimulus(1'b0, TAIL, 0, 1'b1);
        applyStimulus(1'b1, TAIL, 0, 1'b0);
        applyStimulus(1'b1, TAIL, 0, 1'b0);
        checkOutput("south_held", 8'(port_req), 8'h08);
        applyStimulus(1'b1, TAIL, 0, 1'b1);
        checkOutput("south_clear", 8'(port_req), 8'h00);
        checkOutput("south_valid", 8'(req_valid), 8'h00);

        applyStimulus(1'b1, HEADER, 13, 1'b0);
        applyStimulus(1'b1, HEADER, 13, 1'b0);
        checkOutput("hold_hdr_perr", 8'(proto_err), 8'h01);
        checkOutput("hold_hdr_req", 8'(port_req), 8'h08);
        rst = 1'b1;
        applyStimulus(1'b1, PAYLOAD, 0, 1'b1);
        checkOutput("midpkt_rst", 8'(port_req), 8'h00);

        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) begin
                cfg_we = 1'b1;
                cfg_rxy = 8'($urandom);
                cfg_cx = 4'($urandom);
                cfg_dr = 8'($urandom);
                cfg_addr = A_W'($urandom);
            end
            case ($urandom_range(0, 7))
                0, 1:    flit_id = HEADER;
                2, 3, 4: flit_id = PAYLOAD;
                5, 6:    flit_id = TAIL;
                default: flit_id = 3'b000;
            endcase
            applyStimulus($urandom_range(0, 3) != 0, flit_id,
                          int'($urandom_range(0, (1 << A_W) - 1)), $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
